// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one cacheline-wide memory port between the L1
// instruction cache (fills) and the L1 data cache (fills and writebacks).
module pmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_next;
  logic   last_grant_d;  // 1 when D won the most recent grant

  logic req_i, req_d;
  logic grant_i, grant_d;
  logic conflict;
  logic serve_done;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // On a tie the side that did not win last time is granted.
  assign grant_i    = (state == IDLE) && req_i && (!req_d || last_grant_d);
  assign grant_d    = (state == IDLE) && req_d && (!req_i || !last_grant_d);
  assign conflict   = (state == IDLE) && req_i && req_d;
  assign serve_done = ((state == SERVE_I) || (state == SERVE_D)) && m_resp;

  // Read data is shared; only the resp strobe tells a cache the data is valid.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_resp  = (state == SERVE_I) && m_resp;
  assign d_resp  = (state == SERVE_D) && m_resp;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: defaulting next-state first keeps every path assigned, so no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_i)      state_next = SERVE_I;
        else if (grant_d) state_next = SERVE_D;
      end
      SERVE_I: if (m_resp) state_next = DONE;
      SERVE_D: if (m_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      m_addr       <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_wdata      <= '0;
      i_grant_cnt  <= '0;
      d_grant_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      state <= state_next;

      if (conflict) conflict_cnt <= sat_inc(conflict_cnt);

      if (grant_i) begin
        m_addr       <= i_addr;
        m_read       <= 1'b1;
        m_write      <= 1'b0;
        last_grant_d <= 1'b0;
        i_grant_cnt  <= sat_inc(i_grant_cnt);
      end else if (grant_d) begin
        // An illegal read+write request is treated as a writeback.
        m_addr       <= d_addr;
        m_read       <= d_read & ~d_write;
        m_write      <= d_write;
        m_wdata      <= d_wdata;
        last_grant_d <= 1'b1;
        d_grant_cnt  <= sat_inc(d_grant_cnt);
      end else if (serve_done) begin
        m_read  <= 1'b0;
        m_write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter; a second instance with 2-bit counters
// shares the stimulus so counter saturation can be observed.
module tb_pmem_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;
  localparam int SAT_W  = 2;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] m_addr;
  logic              m_read;
  logic              m_write;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;
  logic [CNT_W-1:0]  i_grant_cnt;
  logic [CNT_W-1:0]  d_grant_cnt;
  logic [CNT_W-1:0]  conflict_cnt;

  logic [LINE_W-1:0] s_i_rdata, s_d_rdata, s_m_wdata;
  logic              s_i_resp, s_d_resp, s_m_read, s_m_write;
  logic [ADDR_W-1:0] s_m_addr;
  logic [SAT_W-1:0]  s_i_grant_cnt, s_d_grant_cnt, s_conflict_cnt;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] PAT_3C = {32{8'h3C}};
  localparam logic [LINE_W-1:0] PAT_WR = {8{32'h1234_5678}};

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
  );

  pmem_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) u_sat (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_resp(s_d_resp),
    .m_addr(s_m_addr), .m_read(s_m_read), .m_write(s_m_write), .m_wdata(s_m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp),
    .i_grant_cnt(s_i_grant_cnt), .d_grant_cnt(s_d_grant_cnt), .conflict_cnt(s_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
  endtask

  // Memory model: call in the first strobe cycle; responds in the lat-th
  // strobe cycle and returns in the DONE cycle with m_resp low again.
  task automatic mem_txn(input int lat, input logic [LINE_W-1:0] data,
                         output int strobes, output int i_cnt, output int d_cnt,
                         output logic [LINE_W-1:0] seen);
    strobes = 0; i_cnt = 0; d_cnt = 0; seen = '0;
    for (int n = 1; n <= lat; n++) begin
      if (n == lat) begin
        m_resp  = 1'b1;
        m_rdata = data;
      end
      #1;
      if (m_read || m_write) strobes++;
      if (i_resp) begin i_cnt++; seen = i_rdata; end
      if (d_resp) begin d_cnt++; seen = d_rdata; end
      tick();
      m_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_chk++; if (m_read !== 1'b0)  begin n_err++; $display("FAIL reset_m_read: got %0b expected 0", m_read); end
    n_chk++; if (m_write !== 1'b0) begin n_err++; $display("FAIL reset_m_write: got %0b expected 0", m_write); end
    n_chk++; if (m_addr !== '0)    begin n_err++; $display("FAIL reset_m_addr: got %0h expected 0", m_addr); end
    n_chk++; if (m_wdata !== '0)   begin n_err++; $display("FAIL reset_m_wdata: got %0h expected 0", m_wdata); end
    n_chk++; if ({i_resp, d_resp} !== 2'b00) begin n_err++; $display("FAIL reset_resp: got %b expected 00", {i_resp, d_resp}); end
    n_chk++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== '0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_i_fill();
    int st, ic, dc;
    logic [LINE_W-1:0] seen;
    i_addr = 32'h0000_0060; i_read = 1'b1;
    tick();
    n_chk++; if (m_read !== 1'b1 || m_write !== 1'b0) begin n_err++; $display("FAIL ifill_strobe: got rd=%0b wr=%0b expected rd=1 wr=0", m_read, m_write); end
    n_chk++; if (m_addr !== 32'h60) begin n_err++; $display("FAIL ifill_addr: got %0h expected 60", m_addr); end
    mem_txn(3, PAT_A5, st, ic, dc, seen);
    n_chk++; if (st != 3) begin n_err++; $display("FAIL ifill_read_cycles: got %0d expected 3", st); end
    n_chk++; if (ic != 1 || dc != 0) begin n_err++; $display("FAIL ifill_resp: got i=%0d d=%0d expected i=1 d=0", ic, dc); end
    n_chk++; if (seen !== PAT_A5) begin n_err++; $display("FAIL ifill_rdata: got %0h expected %0h", seen, PAT_A5); end
    n_chk++; if (m_read !== 1'b0 || i_resp !== 1'b0) begin n_err++; $display("FAIL ifill_done: got rd=%0b resp=%0b expected 0 0", m_read, i_resp); end
    i_read = 1'b0;
    tick();
    n_chk++; if (i_grant_cnt !== 32'd1 || d_grant_cnt !== 32'd0) begin n_err++; $display("FAIL ifill_cnt: got i=%0d d=%0d expected i=1 d=0", i_grant_cnt, d_grant_cnt); end
  endtask

  task automatic test_d_writeback();
    int st, ic, dc;
    logic [LINE_W-1:0] seen;
    d_addr = 32'h0000_1000; d_write = 1'b1; d_wdata = PAT_WR;
    tick();
    n_chk++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_err++; $display("FAIL dwb_strobe: got rd=%0b wr=%0b expected rd=0 wr=1", m_read, m_write); end
    n_chk++; if (m_wdata !== PAT_WR) begin n_err++; $display("FAIL dwb_wdata: got %0h expected %0h", m_wdata, PAT_WR); end
    n_chk++; if (m_addr !== 32'h1000) begin n_err++; $display("FAIL dwb_addr: got %0h expected 1000", m_addr); end
    mem_txn(2, PAT_3C, st, ic, dc, seen);
    n_chk++; if (dc != 1 || ic != 0) begin n_err++; $display("FAIL dwb_resp: got i=%0d d=%0d expected i=0 d=1", ic, dc); end
    n_chk++; if (st != 2) begin n_err++; $display("FAIL dwb_write_cycles: got %0d expected 2", st); end
    d_write = 1'b0;
    tick();
    n_chk++; if (d_grant_cnt !== 32'd1) begin n_err++; $display("FAIL dwb_cnt: got %0d expected 1", d_grant_cnt); end
  endtask

  task automatic test_tie();
    int st, ic, dc;
    logic [LINE_W-1:0] seen;
    apply_reset();
    i_addr = 32'h100; d_addr = 32'h200;
    i_read = 1'b1; d_read = 1'b1;
    tick();
    n_chk++; if (m_read !== 1'b1 || m_addr !== 32'h200) begin n_err++; $display("FAIL tie_first_d: got rd=%0b addr=%0h expected rd=1 addr=200", m_read, m_addr); end
    mem_txn(1, PAT_3C, st, ic, dc, seen);
    n_chk++; if (dc != 1 || ic != 0) begin n_err++; $display("FAIL tie_d_resp: got i=%0d d=%0d expected i=0 d=1", ic, dc); end
    n_chk++; if (seen !== PAT_3C) begin n_err++; $display("FAIL tie_d_rdata: got %0h expected %0h", seen, PAT_3C); end
    d_read = 1'b0;
    tick();
    n_chk++; if (m_read !== 1'b0) begin n_err++; $display("FAIL tie_gap: got rd=%0b expected 0", m_read); end
    tick();
    n_chk++; if (m_read !== 1'b1 || m_addr !== 32'h100) begin n_err++; $display("FAIL tie_then_i: got rd=%0b addr=%0h expected rd=1 addr=100", m_read, m_addr); end
    mem_txn(2, PAT_A5, st, ic, dc, seen);
    n_chk++; if (ic != 1 || dc != 0) begin n_err++; $display("FAIL tie_i_resp: got i=%0d d=%0d expected i=1 d=0", ic, dc); end
    i_read = 1'b0;
    tick();
    n_chk++; if (conflict_cnt !== 32'd1) begin n_err++; $display("FAIL tie_conflict: got %0d expected 1", conflict_cnt); end
    n_chk++; if (i_grant_cnt !== 32'd1 || d_grant_cnt !== 32'd1) begin n_err++; $display("FAIL tie_grants: got i=%0d d=%0d expected 1 1", i_grant_cnt, d_grant_cnt); end
  endtask

  task automatic test_round_robin();
    int st, ic, dc;
    logic [LINE_W-1:0] seen;
    logic exp_d;
    i_read = 1'b1; d_read = 1'b1;
    for (int n = 0; n < 6; n++) begin
      exp_d = (n % 2 == 0);
      tick();
      n_chk++; if (m_read !== 1'b1 || m_addr !== (exp_d ? 32'h200 : 32'h100)) begin n_err++; $display("FAIL rr_order_%0d: got rd=%0b addr=%0h expected rd=1 addr=%0h", n, m_read, m_addr, exp_d ? 32'h200 : 32'h100); end
      mem_txn(1, PAT_A5, st, ic, dc, seen);
      n_chk++; if (dc != int'(exp_d) || ic != int'(!exp_d)) begin n_err++; $display("FAIL rr_resp_%0d: got i=%0d d=%0d expected i=%0d d=%0d", n, ic, dc, !exp_d, exp_d); end
      if (exp_d) d_read = 1'b0; else i_read = 1'b0;
      tick();
      if (n < 5) begin
        if (exp_d) d_read = 1'b1; else i_read = 1'b1;
      end else begin
        i_read = 1'b0; d_read = 1'b0;
      end
    end
    tick();
    n_chk++; if (i_grant_cnt !== 32'd4 || d_grant_cnt !== 32'd4) begin n_err++; $display("FAIL rr_grants: got i=%0d d=%0d expected 4 4", i_grant_cnt, d_grant_cnt); end
    n_chk++; if (conflict_cnt !== 32'd7) begin n_err++; $display("FAIL rr_conflict: got %0d expected 7", conflict_cnt); end
  endtask

  task automatic test_stray_and_reset();
    int st, ic, dc;
    logic [LINE_W-1:0] seen;
    apply_reset();
    m_resp = 1'b1; m_rdata = PAT_A5;
    #1;
    n_chk++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin n_err++; $display("FAIL stray_resp: got i=%0b d=%0b expected 0 0", i_resp, d_resp); end
    tick();
    m_resp = 1'b0;
    n_chk++; if (m_read !== 1'b0 || m_write !== 1'b0) begin n_err++; $display("FAIL stray_strobe: got rd=%0b wr=%0b expected 0 0", m_read, m_write); end
    i_addr = 32'h340; i_read = 1'b1;
    tick();
    tick();
    n_chk++; if (m_read !== 1'b1) begin n_err++; $display("FAIL rst_pre_serve: got rd=%0b expected 1", m_read); end
    rst = 1'b0; m_resp = 1'b1;
    #1;
    n_chk++; if (m_read !== 1'b0) begin n_err++; $display("FAIL rst_async_drop: got rd=%0b expected 0", m_read); end
    n_chk++; if (i_resp !== 1'b0) begin n_err++; $display("FAIL rst_no_resp: got %0b expected 0", i_resp); end
    n_chk++; if ({i_grant_cnt, d_grant_cnt, conflict_cnt} !== '0) begin n_err++; $display("FAIL rst_counters: got %0d/%0d/%0d expected 0/0/0", i_grant_cnt, d_grant_cnt, conflict_cnt); end
    m_resp = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_chk++; if (m_read !== 1'b1 || m_addr !== 32'h340) begin n_err++; $display("FAIL rst_regrant: got rd=%0b addr=%0h expected rd=1 addr=340", m_read, m_addr); end
    n_chk++; if (i_grant_cnt !== 32'd1) begin n_err++; $display("FAIL rst_regrant_cnt: got %0d expected 1", i_grant_cnt); end
    mem_txn(1, PAT_3C, st, ic, dc, seen);
    n_chk++; if (ic != 1) begin n_err++; $display("FAIL rst_regrant_resp: got %0d expected 1", ic); end
    i_read = 1'b0;
    tick();
  endtask

  task automatic test_illegal_and_saturation();
    int st, ic, dc;
    logic [LINE_W-1:0] seen;
    apply_reset();
    d_addr = 32'h400; d_wdata = PAT_3C; d_read = 1'b1; d_write = 1'b1;
    tick();
    n_chk++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_err++; $display("FAIL illegal_op: got rd=%0b wr=%0b expected rd=0 wr=1", m_read, m_write); end
    mem_txn(1, PAT_A5, st, ic, dc, seen);
    n_chk++; if (dc != 1) begin n_err++; $display("FAIL illegal_resp: got %0d expected 1", dc); end
    d_read = 1'b0; d_write = 1'b0;
    tick();
    i_addr = 32'h80;
    for (int n = 1; n <= 5; n++) begin
      i_read = 1'b1;
      tick();
      mem_txn(1, PAT_A5, st, ic, dc, seen);
      i_read = 1'b0;
      tick();
      n_chk++; if (s_i_grant_cnt !== SAT_W'((n > 3) ? 3 : n)) begin n_err++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", n, s_i_grant_cnt, (n > 3) ? 3 : n); end
      n_chk++; if (i_grant_cnt !== CNT_W'(n)) begin n_err++; $display("FAIL wide_cnt_%0d: got %0d expected %0d", n, i_grant_cnt, n); end
    end
  endtask

  initial begin
    rst = 1'b0;
    i_addr = '0; i_read = 1'b0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    m_rdata = '0; m_resp = 1'b0;
    test_reset();
    test_i_fill();
    test_d_writeback();
    test_tie();
    test_round_robin();
    test_stray_and_reset();
    test_illegal_and_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
